// File: rtl/z80_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : z80_bus_responder
// Purpose  : Z80 bus slave. Decodes CPU memory read/write cycles (and I/O
//            cycles when Z80_BUS_RESPONDER_IO_EN is defined), holds nWAIT low
//            while the access is serviced, bridges each cycle onto a simple
//            req/ack memory port and returns read data toward the CPU.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            address, nMREQ, nIORQ, nRD, nWR, nRFSH, db_in - CPU side inputs
//            db_out, db_oe, nWAIT  - CPU side outputs (registered)
//            mem_req, mem_we, mem_io, mem_addr, mem_wdata  - memory request
//            mem_rdata, mem_ack    - memory response
//            busy                  - high whenever a cycle is in progress
// Options  : Z80_BUS_RESPONDER_IO_EN - also service I/O (nIORQ) cycles.
// Revision : 1.0 - initial release
// ============================================================================
module z80_bus_responder #(
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              nMREQ,
  input  logic              nIORQ,
  input  logic              nRD,
  input  logic              nWR,
  input  logic              nRFSH,
  input  logic [7:0]        db_in,
  output logic [7:0]        db_out,
  output logic              db_oe,
  output logic              nWAIT,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_io,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic              busy
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              abort_q, abort_d;
  logic [7:0]        db_out_q, db_out_d;
  logic              db_oe_q, db_oe_d;
  logic              nwait_q, nwait_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_io_q, mem_io_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;

  logic       strobe;
  logic       strobes_idle;
  logic       mem_start;
  logic       io_start;
  logic [3:0] cnt_dec;
  logic       ack_now;
  logic       acked;

  assign strobe       = ~nRD | ~nWR;
  assign strobes_idle = nRD & nWR;
  // Refresh cycles carry nMREQ low with nRFSH low; they must never start.
  assign mem_start    = ~nMREQ & nRFSH & strobe;

`ifdef Z80_BUS_RESPONDER_IO_EN
  // Memory cycle wins when both requests are low; INTA (no strobe) ignored.
  assign io_start = nMREQ & ~nIORQ & strobe;
`else
  logic unused_niorq;
  assign unused_niorq = nIORQ;
  assign io_start     = 1'b0;
`endif

  assign cnt_dec = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
  // Ack is only honoured while a request is outstanding.
  assign ack_now = mem_req_q & mem_ack;
  // The request drops on the ack edge, so a low mem_req in ACCESS means done.
  assign acked   = ack_now | ~mem_req_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    abort_d     = abort_q;
    db_out_d    = db_out_q;
    db_oe_d     = db_oe_q;
    nwait_d     = nwait_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_io_d    = mem_io_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (mem_start || io_start) begin
          state_d     = ACCESS;
          mem_addr_d  = address;
          mem_wdata_d = db_in;
          // Both strobes low resolves to a read.
          mem_we_d    = ~nWR & nRD;
          mem_io_d    = io_start;
          mem_req_d   = 1'b1;
          nwait_d     = 1'b0;
          cnt_d       = WAIT_INIT;
          abort_d     = 1'b0;
        end
      end
      ACCESS: begin
        cnt_d = cnt_dec;
        if (ack_now) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) db_out_d = mem_rdata;
        end
        if (abort_q || strobes_idle) begin
          // CPU walked away: release nWAIT now, but let memory finish.
          nwait_d = 1'b1;
          abort_d = 1'b1;
          if (acked) state_d = RELEASE;
        end else if (acked && cnt_dec == 4'd0) begin
          // Using the decremented count keeps nWAIT low exactly
          // max(WAIT_STATES, ack latency) cycles.
          state_d = HOLD;
          nwait_d = 1'b1;
          db_oe_d = ~mem_we_q;
        end
      end
      HOLD: begin
        if (strobes_idle) begin
          state_d = RELEASE;
          db_oe_d = 1'b0;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      abort_q     <= 1'b0;
      db_out_q    <= 8'h00;
      db_oe_q     <= 1'b0;
      nwait_q     <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_io_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      abort_q     <= abort_d;
      db_out_q    <= db_out_d;
      db_oe_q     <= db_oe_d;
      nwait_q     <= nwait_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_io_q    <= mem_io_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign db_out    = db_out_q;
  assign db_oe     = db_oe_q;
  assign nWAIT     = nwait_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_io    = mem_io_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire
